// File: rtl/maquina_preparo_pkg.sv
// Shared definitions for the drink preparation sequencer: drink codes, selection status codes,
// state/ETAPA encodings and the Moore output decode.
package maquina_preparo_pkg;

  typedef enum logic [2:0] {
    E_OCIOSO = 3'b000,
    E_AQUECE = 3'b001,
    E_PO     = 3'b010,
    E_AGUA   = 3'b011,
    E_LEITE  = 3'b100,
    E_CHOC   = 3'b101,
    E_PRONTO = 3'b110,
    E_ERR    = 3'b111
  } etapa_t;

  localparam logic [3:0] BEB_ESPRESSO   = 4'b0001;
  localparam logic [3:0] BEB_COM_LEITE  = 4'b0010;
  localparam logic [3:0] BEB_CHA        = 4'b0011;
  localparam logic [3:0] BEB_CAPPUCCINO = 4'b0100;

  localparam logic [1:0] ST_ANALISE   = 2'b00;
  localparam logic [1:0] ST_SELECIONA = 2'b01;
  localparam logic [1:0] ST_NENHUMA   = 2'b10;
  localparam logic [1:0] ST_ESCOLHIDA = 2'b11;

  typedef struct packed {
    logic aquecedor;
    logic valv_agua;
    logic dose_cafe;
    logic dose_cha;
    logic dose_leite;
    logic dose_choc;
    logic ocupado;
    logic pronto;
    logic erro;
  } saidas_t;

  function automatic logic bebida_valida(input logic [3:0] b);
    return (b >= BEB_ESPRESSO) && (b <= BEB_CAPPUCCINO);
  endfunction

  function automatic saidas_t decodifica_saidas(input etapa_t e, input logic [3:0] b);
    saidas_t s;
    s = '0;
    case (e)
      E_AQUECE: begin
        s.aquecedor = 1'b1;
        s.ocupado   = 1'b1;
      end
      E_PO: begin
        s.ocupado = 1'b1;
        if (b == BEB_CHA) begin
          s.dose_cha = 1'b1;
        end else begin
          s.dose_cafe = 1'b1;
        end
      end
      E_AGUA: begin
        s.valv_agua = 1'b1;
        s.ocupado   = 1'b1;
      end
      E_LEITE: begin
        s.dose_leite = 1'b1;
        s.ocupado    = 1'b1;
      end
      E_CHOC: begin
        s.dose_choc = 1'b1;
        s.ocupado   = 1'b1;
      end
      E_PRONTO: s.pronto = 1'b1;
      E_ERR:    s.erro   = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/maquina_preparo_contador_fase.sv
// Loadable down-counter used for every timed phase and the heating timeout.
// Load wins over enable; the count holds at zero.
module contador_fase #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [CW-1:0] i_valor,
  output logic          o_zero
);

  logic [CW-1:0] r_conta;

  // phase count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conta <= '0;
    end else if (i_load) begin
      r_conta <= i_valor;
    end else if (i_en && (r_conta != '0)) begin
      r_conta <= r_conta - CW'(1);
    end
  end

  assign o_zero = (r_conta == '0);

endmodule

// File: rtl/maquina_preparo.sv
// Drink preparation sequencer: on a new "chosen" edge from the selection FSM it runs the
// recipe as timed phases and drives registered actuator enables and status indicators.
module maquina_preparo
  import maquina_preparo_pkg::*;
#(
  parameter int CW           = 8,
  parameter int T_AQUECE_MAX = 32,
  parameter int T_PO         = 4,
  parameter int T_AGUA       = 8,
  parameter int T_LEITE      = 6,
  parameter int T_CHOC       = 3,
  parameter int T_PRONTO     = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_status,
  input  logic [3:0] i_bebida,
  input  logic       i_agua_quente,
  input  logic       i_cancela,
  output logic       o_aquecedor,
  output logic       o_valv_agua,
  output logic       o_dose_cafe,
  output logic       o_dose_cha,
  output logic       o_dose_leite,
  output logic       o_dose_choc,
  output logic       o_ocupado,
  output logic       o_pronto,
  output logic       o_erro,
  output logic [2:0] o_etapa
);

  localparam logic [CW-1:0] L_AQUECE = CW'(T_AQUECE_MAX - 1);
  localparam logic [CW-1:0] L_PO     = CW'(T_PO - 1);
  localparam logic [CW-1:0] L_AGUA   = CW'(T_AGUA - 1);
  localparam logic [CW-1:0] L_LEITE  = CW'(T_LEITE - 1);
  localparam logic [CW-1:0] L_CHOC   = CW'(T_CHOC - 1);
  localparam logic [CW-1:0] L_PRONTO = CW'(T_PRONTO - 1);

  etapa_t        r_state;
  logic [3:0]    r_bebida;
  logic [1:0]    r_status_ant;
  saidas_t       r_saidas;

  etapa_t        w_nxt;
  logic          w_trigger;
  logic          w_latch;
  logic          w_load;
  logic          w_en;
  logic [CW-1:0] w_valor;
  logic          w_zero;

  contador_fase #(.CW(CW)) u_contador (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_en    (w_en),
    .i_valor (w_valor),
    .o_zero  (w_zero)
  );

  // History is kept in every state, so a STATUS held at 11 can never look like a new edge
  assign w_trigger = (i_status == ST_ESCOLHIDA) && (r_status_ant != ST_ESCOLHIDA);

  // next-state and phase counter control
  always_comb begin
    w_nxt   = r_state;
    w_latch = 1'b0;
    w_load  = 1'b0;
    w_en    = 1'b0;
    w_valor = '0;
    case (r_state)
      E_OCIOSO: begin
        if (w_trigger) begin
          w_latch = 1'b1;
          if (bebida_valida(i_bebida)) begin
            w_nxt   = E_AQUECE;
            w_load  = 1'b1;
            w_valor = L_AQUECE;
          end else begin
            w_nxt = E_ERR;
          end
        end else begin
          w_nxt = E_OCIOSO;
        end
      end
      E_AQUECE: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else if (i_agua_quente) begin
          w_nxt   = E_PO;
          w_load  = 1'b1;
          w_valor = L_PO;
        end else if (w_zero) begin
          w_nxt = E_ERR;
        end else begin
          w_en = 1'b1;
        end
      end
      E_PO: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else if (w_zero) begin
          w_nxt   = E_AGUA;
          w_load  = 1'b1;
          w_valor = L_AGUA;
        end else begin
          w_en = 1'b1;
        end
      end
      E_AGUA: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else if (w_zero) begin
          if ((r_bebida == BEB_COM_LEITE) || (r_bebida == BEB_CAPPUCCINO)) begin
            w_nxt   = E_LEITE;
            w_load  = 1'b1;
            w_valor = L_LEITE;
          end else begin
            w_nxt   = E_PRONTO;
            w_load  = 1'b1;
            w_valor = L_PRONTO;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      E_LEITE: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else if (w_zero) begin
          if (r_bebida == BEB_CAPPUCCINO) begin
            w_nxt   = E_CHOC;
            w_load  = 1'b1;
            w_valor = L_CHOC;
          end else begin
            w_nxt   = E_PRONTO;
            w_load  = 1'b1;
            w_valor = L_PRONTO;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      E_CHOC: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else if (w_zero) begin
          w_nxt   = E_PRONTO;
          w_load  = 1'b1;
          w_valor = L_PRONTO;
        end else begin
          w_en = 1'b1;
        end
      end
      E_PRONTO: begin
        if (i_cancela || w_zero) begin
          w_nxt = E_OCIOSO;
        end else begin
          w_en = 1'b1;
        end
      end
      E_ERR: begin
        if (i_cancela) begin
          w_nxt = E_OCIOSO;
        end else begin
          w_nxt = E_ERR;
        end
      end
      default: w_nxt = E_OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= E_OCIOSO;
      r_bebida     <= 4'b0000;
      r_status_ant <= ST_ANALISE;
      r_saidas     <= '0;
    end else begin
      r_state      <= w_nxt;
      r_status_ant <= i_status;
      r_saidas     <= decodifica_saidas(w_nxt, r_bebida);
      if (w_latch) begin
        r_bebida <= i_bebida;
      end
    end
  end

  assign o_aquecedor  = r_saidas.aquecedor;
  assign o_valv_agua  = r_saidas.valv_agua;
  assign o_dose_cafe  = r_saidas.dose_cafe;
  assign o_dose_cha   = r_saidas.dose_cha;
  assign o_dose_leite = r_saidas.dose_leite;
  assign o_dose_choc  = r_saidas.dose_choc;
  assign o_ocupado    = r_saidas.ocupado;
  assign o_pronto     = r_saidas.pronto;
  assign o_erro       = r_saidas.erro;
  assign o_etapa      = r_state;

endmodule
